// File: rtl/freq_meter.sv
// Frequency / period / high-time meter for a square wave that is asynchronous to clk.
// Edges are detected after a two-flop synchronizer and counted over a fixed gate window.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             no_signal,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time
);

    localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        if (inc && (a != CNT_MAX))
            return a + CNT_ONE;
        return a;
    endfunction

    logic              sync_p0_q, sync_p1_q, sync_p2_q;
    logic              s, d, rise, fall;

    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_q, edge_d, edge_sum;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              nosig_q, nosig_d;
    logic              fv_q, fv_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              pv_q, pv_d;
    logic [CNT_W-1:0]  high_q, high_d;

    // Synchronizer stages p0/p1 give s; p2 is the one-cycle-old copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
            sync_p2_q <= 1'b0;
        end else begin
            sync_p0_q <= sig_in;
            sync_p1_q <= sync_p0_q;
            sync_p2_q <= sync_p1_q;
        end
    end

    assign s    = sync_p1_q;
    assign d    = sync_p2_q;
    assign rise = s & ~d;
    assign fall = ~s & d;

    always_comb begin
        gate_d   = gate_q;
        edge_d   = edge_q;
        per_d    = per_q;
        hi_d     = hi_q;
        armed_d  = armed_q;
        freq_d   = freq_q;
        nosig_d  = nosig_q;
        fv_d     = 1'b0;
        period_d = period_q;
        pv_d     = 1'b0;
        high_d   = high_q;
        edge_sum = sat_inc(edge_q, rise);

        if (en) begin
            // A rise in the last window cycle still belongs to the closing window.
            if (gate_q == GATE_LAST) begin
                freq_d  = edge_sum;
                nosig_d = (edge_sum == '0);
                fv_d    = 1'b1;
                edge_d  = '0;
                gate_d  = '0;
            end else begin
                edge_d  = edge_sum;
                gate_d  = gate_q + GATE_W'(1);
            end

            per_d = sat_inc(per_q, 1'b1);
            if (rise) begin
                if (armed_q) begin
                    period_d = per_q;
                    pv_d     = 1'b1;
                end
                armed_d = 1'b1;
                per_d   = CNT_ONE;
            end

            // armed doubles as "a rise was seen", so a high phase already running at enable is dropped.
            if (rise)
                hi_d = CNT_ONE;
            else if (s)
                hi_d = sat_inc(hi_q, 1'b1);
            if (fall && armed_q)
                high_d = hi_q;
        end else begin
            gate_d  = '0;
            edge_d  = '0;
            per_d   = '0;
            hi_d    = '0;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q   <= '0;
            edge_q   <= '0;
            per_q    <= '0;
            hi_q     <= '0;
            armed_q  <= 1'b0;
            freq_q   <= '0;
            nosig_q  <= 1'b0;
            fv_q     <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            high_q   <= '0;
        end else begin
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            armed_q  <= armed_d;
            freq_q   <= freq_d;
            nosig_q  <= nosig_d;
            fv_q     <= fv_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            high_q   <= high_d;
        end
    end

    assign freq         = freq_q;
    assign freq_valid   = fv_q;
    assign no_signal    = nosig_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign high_time    = high_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 32-bit and an 8-bit instance with a 1000-cycle gate window,
// checked every cycle against an event-timestamp model plus hand-computed literals.
module tb_freq_meter;

    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, en8 = 1'b0;
    logic        sig_in = 1'b0, sig8 = 1'b0;
    logic [31:0] freq, period, high_time;
    logic        freq_valid, no_signal, period_valid;
    logic [7:0]  freq8, period8, high8;
    logic        fv8, nosig8, pv8;

    int checks = 0;
    int failures = 0;

    int gen_per = 10, gen_hi = 5, ph = 0;
    bit gen_on = 1'b0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq), .freq_valid(freq_valid), .no_signal(no_signal),
        .period(period), .period_valid(period_valid), .high_time(high_time)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .sig_in(sig8),
        .freq(freq8), .freq_valid(fv8), .no_signal(nosig8),
        .period(period8), .period_valid(pv8), .high_time(high8)
    );

    // Stimulus waveforms change on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        sig8 = ~sig8;
        if (gen_on) begin
            sig_in = (ph < gen_hi);
            ph = (ph + 1 >= gen_per) ? 0 : ph + 1;
        end else begin
            sig_in = 1'b0;
            ph = 0;
        end
    end

    typedef struct {
        logic   f1, s, d;
        longint rises;
        int     wpos;
        bit     armed;
        longint last_rise, hstart;
        longint freq, period, high;
        bit     nosig, fv, pv;
    } model_t;

    model_t m32, m8;
    longint cyc = 0;

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    // Measurements from event timestamps: edges per window, rise-to-rise and rise-to-fall distances.
    task automatic mstep(inout model_t m, input logic en_v, input logic sig_v,
                         input longint maxv, input longint t);
        logic r, f;
        r = m.s & ~m.d;
        f = ~m.s & m.d;
        m.d  = m.s;
        m.s  = m.f1;
        m.f1 = sig_v;
        m.fv = 1'b0;
        m.pv = 1'b0;
        if (!en_v) begin
            m.rises = 0;
            m.wpos  = 0;
            m.armed = 1'b0;
        end else begin
            if (r) m.rises++;
            m.wpos++;
            if (m.wpos == G) begin
                m.freq  = lmin(m.rises, maxv);
                m.nosig = (m.rises == 0);
                m.fv    = 1'b1;
                m.rises = 0;
                m.wpos  = 0;
            end
            if (f && m.armed) m.high = lmin(t - m.hstart, maxv);
            if (r) begin
                if (m.armed) begin
                    m.period = lmin(t - m.last_rise, maxv);
                    m.pv     = 1'b1;
                end
                m.armed     = 1'b1;
                m.last_rise = t;
                m.hstart    = t;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        cyc++;
        if (!rst) begin
            m32 = '{default: 0};
            m8  = '{default: 0};
        end else begin
            mstep(m32, en, sig_in, 64'hFFFF_FFFF, cyc);
            mstep(m8, en8, sig8, 64'hFF, cyc);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("freq", longint'(freq), m32.freq);
        chk("freq_valid", longint'(freq_valid), longint'(m32.fv));
        chk("no_signal", longint'(no_signal), longint'(m32.nosig));
        chk("period", longint'(period), m32.period);
        chk("period_valid", longint'(period_valid), longint'(m32.pv));
        chk("high_time", longint'(high_time), m32.high);
        chk("freq8", longint'(freq8), m8.freq);
        chk("freq_valid8", longint'(fv8), longint'(m8.fv));
        chk("no_signal8", longint'(nosig8), longint'(m8.nosig));
        chk("period8", longint'(period8), m8.period);
        chk("period_valid8", longint'(pv8), longint'(m8.pv));
        chk("high_time8", longint'(high8), m8.high);
    end

    task automatic wait_fv(input bit narrow, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(narrow ? fv8 : freq_valid) && n < budget);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_freq"}, longint'(freq), 0);
        chk({tag, "_fv"}, longint'(freq_valid), 0);
        chk({tag, "_nosig"}, longint'(no_signal), 0);
        chk({tag, "_period"}, longint'(period), 0);
        chk({tag, "_pv"}, longint'(period_valid), 0);
        chk({tag, "_high"}, longint'(high_time), 0);
        chk({tag, "_freq8"}, longint'(freq8), 0);
        chk({tag, "_period8"}, longint'(period8), 0);
    endtask

    initial begin
        int n, cnt_fv, cnt_pv;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b1;

        // 5 high / 5 low, period 10
        gen_per = 10; gen_hi = 5; gen_on = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_fv(1'b0, 1100, n);
        chk("t1_first_fv_latency", n, 1000);
        chk("t1_freq", longint'(freq), 100);
        chk("t1_nosig", longint'(no_signal), 0);
        chk("t1_period", longint'(period), 10);
        chk("t1_high", longint'(high_time), 5);
        wait_fv(1'b0, 1100, n);
        chk("t1_second_fv_latency", n, 1000);
        chk("t1_freq2", longint'(freq), 100);

        // Drop enable mid-window, then re-enable
        repeat (500) @(posedge clk);
        @(negedge clk) en = 1'b0;
        cnt_fv = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (freq_valid) cnt_fv++;
        end
        chk("t3_fv_while_off", cnt_fv, 0);
        chk("t3_freq_held", longint'(freq), 100);
        @(negedge clk) en = 1'b1;
        wait_fv(1'b0, 1100, n);
        chk("t3_fv_latency", n, 1000);
        chk("t3_freq", longint'(freq), 100);

        // Silent input
        @(negedge clk) begin en = 1'b0; gen_on = 1'b0; end
        repeat (10) @(negedge clk);
        en = 1'b1;
        cnt_fv = 0; cnt_pv = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (freq_valid) cnt_fv++;
            if (period_valid) cnt_pv++;
        end
        chk("t2_fv_count", cnt_fv, 3);
        chk("t2_pv_count", cnt_pv, 0);
        chk("t2_freq", longint'(freq), 0);
        chk("t2_nosig", longint'(no_signal), 1);

        // 3 high / 7 low
        @(negedge clk) en = 1'b0;
        gen_per = 10; gen_hi = 3; gen_on = 1'b1;
        repeat (15) @(negedge clk);
        en = 1'b1;
        n = 0; cnt_pv = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (period_valid) cnt_pv++;
        end while (!freq_valid && n < 1100);
        chk("t5_fv_latency", n, 1000);
        chk("t5_pv_count", cnt_pv, 99);
        chk("t5_freq", longint'(freq), 100);
        chk("t5_period", longint'(period), 10);
        chk("t5_high", longint'(high_time), 3);

        // 8-bit instance, input toggling every clk
        @(negedge clk) en8 = 1'b1;
        wait_fv(1'b1, 1100, n);
        chk("t4_fv_latency", n, 1000);
        chk("t4_freq_sat", longint'(freq8), 255);
        chk("t4_nosig", longint'(nosig8), 0);
        chk("t4_period", longint'(period8), 2);
        chk("t4_high", longint'(high8), 1);

        // Asynchronous reset mid-window
        @(negedge clk) en = 1'b0;
        gen_per = 10; gen_hi = 5;
        repeat (15) @(negedge clk);
        en = 1'b1;
        wait_fv(1'b0, 1100, n);
        chk("t6_pre_fv_latency", n, 1000);
        repeat (437) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("t6_reset");
        @(negedge clk) rst = 1'b1;
        wait_fv(1'b0, 1100, n);
        chk("t6_fv_latency", n, 1000);
        wait_fv(1'b0, 1100, n);
        chk("t6_freq", longint'(freq), 100);
        chk("t6_period", longint'(period), 10);
        chk("t6_high", longint'(high_time), 5);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures an external or divided-down square wave, the receive-side counterpart of the team's clock dividers.
- sig_in is asynchronous to clk and is first passed through a synchronizer.
- The block reports three measurements:
  - rising-edge count per fixed gate window (frequency);
  - clk cycles between consecutive rising edges (period);
  - clk cycles of the last high phase (high time).
- Used for board self-test of divider outputs and for measuring external inputs shown on the seven-segment display.

Parameters:
GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz).
CNT_W, 32, width of all counters and result outputs.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  measurement enable; low clears the measurement, high runs it.
sig_in  input  1  signal to measure, asynchronous to clk.
freq  output  CNT_W  rising edges counted in the last completed gate window (saturating).
freq_valid  output  1  one-cycle pulse when freq updates.
no_signal  output  1  set to 1 when the last completed window contained zero edges.
period  output  CNT_W  clk cycles between the last two rising edges (saturating).
period_valid  output  1  one-cycle pulse when period updates.
high_time  output  CNT_W  clk cycles sig_in was high in the last complete high phase (saturating).

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk. While rst=0, every register is 0, including:
  - outputs: freq, freq_valid, no_signal, period, period_valid, high_time;
  - internal: synchronizer flops, edge_cnt, gate_cnt, per_cnt, hi_cnt, armed.
- Synchronizer and edge detection:
  - sig_in goes through 2 flops to give s, then 1 more flop to give d.
  - rise = s & ~d; fall = ~s & d.
  - A sig_in transition sampled at clk edge k makes rise/fall true in the cycle after edge k+1.
- Gate counter:
  - While en=1, gate_cnt counts 0..GATE_CYCLES-1 and wraps.
  - When gate_cnt==GATE_CYCLES-1 (last window cycle), at the next edge:
    - freq <= sat(edge_cnt + rise), so a rise in the last cycle counts in the current window;
    - no_signal <= (edge_cnt + rise == 0);
    - freq_valid <= 1; edge_cnt <= 0; gate_cnt <= 0.
  - Otherwise, edge_cnt <= sat(edge_cnt + rise).
  - The first freq_valid occurs exactly GATE_CYCLES clk edges after the first edge that samples en=1.
- Period:
  - per_cnt increments by 1 every cycle, saturating at all-ones.
  - On rise with armed=1: period <= per_cnt, period_valid <= 1, per_cnt <= 1.
  - On rise with armed=0 (first edge after reset or en): armed <= 1, per_cnt <= 1, no period_valid.
  - Rises at cycles t1 and t2 give period = t2 - t1.
- High time:
  - On rise, hi_cnt <= 1.
  - While s=1 and no rise, hi_cnt <= sat(hi_cnt + 1).
  - On fall, high_time <= hi_cnt, but only if a rise has been seen since reset/en.
  - A high phase already in progress when en rises is discarded.
- Saturation: all counters and results clamp at 2^CNT_W - 1 and never wrap.
- en=0:
  - cleared: gate_cnt, edge_cnt, per_cnt, hi_cnt, armed;
  - forced to 0: freq_valid, period_valid;
  - held at last values: freq, no_signal, period, high_time;
  - the synchronizer keeps running.
- Dropping en mid-window discards the partial window; no freq_valid is produced.
- Simultaneous events:
  - rise on the last gate cycle: counted in the closing window, and period is updated in the same cycle;
  - freq_valid and period_valid may assert in the same cycle.
- Reset mid-operation: everything clears immediately; measurement restarts at the first edge after rst=1 with en=1.

Test Plan:
1. GATE_CYCLES=1000; sig_in period 10 clk (5 high/5 low), generated synchronously to clk; en=1 -> every freq_valid (once per 1000 cycles) shows freq=100, no_signal=0; period=10; high_time=5.
2. sig_in held 0; en=1 for 3000 cycles -> three freq_valid pulses, each with freq=0 and no_signal=1; period_valid never asserts.
3. Signal from test 1; en dropped at window cycle 500 and restored 200 cycles later -> no freq_valid while en=0; freq holds 100; next freq_valid exactly 1000 edges after en re-sampled high, with freq=100.
4. CNT_W=8, GATE_CYCLES=1000; sig_in toggles every clk (period 2) -> freq=255 (saturated), period=2, high_time=1.
5. Duty 3 high/7 low -> period=10, high_time=3, freq=100; the first rise after en produces no period_valid.
6. rst pulled low at window cycle 437 with the test 1 signal running -> all outputs 0 in the same cycle; after release, the first freq_valid arrives 1000 cycles after en is sampled, with freq=100.
